// File: rtl/verify_pin_pkg.sv
// verify_pin_pkg
//   Shared types and helpers for the door-lock PIN checker.
//   pinPac_t       : assembled PIN packet (status + 4 BCD digits, digits[3] entered first)
//   verify_state_t : checker FSM states
//   PIN_BLANK      : digit code for an unfilled position
//   pin_equal()    : digit-wise compare that rejects any blank digit
//   lockout_time() : base lockout seconds shifted by escalation level, saturating at 255
package verify_pin_pkg;

    typedef struct packed {
        logic            status;
        logic [3:0][3:0] digits;
    } pinPac_t;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        GRANT,
        LOCKOUT
    } verify_state_t;

    localparam logic [3:0] PIN_BLANK = 4'hF;

    function automatic logic pin_equal(input pinPac_t a, input pinPac_t b);
        logic eq;
        eq = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            if ((a.digits[i] != b.digits[i]) || (a.digits[i] == PIN_BLANK)) begin
                eq = 1'b0;
            end
        end
        return eq;
    endfunction

    function automatic logic [7:0] lockout_time(input logic [7:0] base, input logic [2:0] lvl);
        logic [15:0] t;
        t = {8'h00, base} << lvl;
        return (t > 16'd255) ? 8'hFF : t[7:0];
    endfunction

endpackage

// File: rtl/verify_pin_if.sv
// verify_pin_if
//   Bundle between the PIN front end and the access checker.
//   pin_in, master_pin        : PIN packets into the checker
//   unlock, denied, locked    : checker status outputs
//   fail_cnt, lock_secs       : failure count and lockout seconds remaining
//   modport master : drives the PIN packets, observes results
//   modport slave  : the checker side
interface verify_pin_if;
    import verify_pin_pkg::*;

    pinPac_t    pin_in;
    pinPac_t    master_pin;
    logic       unlock;
    logic       denied;
    logic       locked;
    logic [3:0] fail_cnt;
    logic [7:0] lock_secs;

    modport master (
        output pin_in, master_pin,
        input  unlock, denied, locked, fail_cnt, lock_secs
    );

    modport slave (
        input  pin_in, master_pin,
        output unlock, denied, locked, fail_cnt, lock_secs
    );

endinterface

// File: rtl/verify_pin_sec_timer.sv
// verify_pin_sec_timer
//   Loadable seconds down-counter with a TICK_HZ prescaler.
//   clk, rst  : clock, async active-high reset
//   load_i    : load value_i and restart the prescaler
//   value_i   : seconds to count down
//   secs_o    : whole seconds remaining
//   done_o    : 1-cycle pulse in the cycle whose closing edge reaches zero
module verify_pin_sec_timer #(
    parameter int TICK_HZ = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic [7:0] value_i,
    output logic [7:0] secs_o,
    output logic       done_o
);

    localparam int            PW        = (TICK_HZ > 1) ? $clog2(TICK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_HZ - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    secs_q, secs_d;
    logic          wrap;

    assign wrap = (presc_q == PRESC_MAX);

    always_comb begin
        presc_d = presc_q;
        secs_d  = secs_q;
        if (load_i) begin
            presc_d = '0;
            secs_d  = value_i;
        end else if (secs_q != 8'd0) begin
            if (wrap) begin
                presc_d = '0;
                secs_d  = secs_q - 8'd1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            secs_q  <= '0;
        end else begin
            presc_q <= presc_d;
            secs_q  <= secs_d;
        end
    end

    // Combinational so the FSM can drop its outputs on the same edge secs_q hits 0.
    assign done_o = !load_i && (secs_q == 8'd1) && wrap;
    assign secs_o = secs_q;

endmodule

// File: rtl/verify_pin.sv
// verify_pin
//   Door-lock access checker. Compares each completed PIN entry with the stored
//   master PIN; grants a timed unlock or pulses denied, and locks out after
//   MAX_FAILS consecutive failures.
//   clk, rst       : tick clock, async active-high reset
//   bus (slave)    : pin_in / master_pin in; unlock, denied, locked,
//                    fail_cnt, lock_secs out
//   Optional build macro LOCKOUT_ESCALATE_EN: consecutive lockouts without an
//   intervening grant double in length (saturating at 255 s).
module verify_pin
    import verify_pin_pkg::*;
#(
    parameter int TICK_HZ      = 1000,
    parameter int UNLOCK_SECS  = 5,
    parameter int MAX_FAILS    = 3,
    parameter int LOCKOUT_SECS = 30
) (
    input  logic         clk,
    input  logic         rst,
    verify_pin_if.slave  bus
);

    verify_state_t state_q;
    logic          prev_q;
    logic          unlock_q, denied_q, locked_q;
    logic [3:0]    fail_q, fail_d;

    logic          attempt, match, to_lock;
    logic          tmr_load, tmr_done;
    logic [7:0]    tmr_value, tmr_secs, lock_load;

    // prev_q resets to 1 so a status already high out of reset is not an attempt.
    assign attempt = bus.pin_in.status & ~prev_q;
    assign match   = bus.master_pin.status & pin_equal(bus.pin_in, bus.master_pin);
    assign fail_d  = fail_q + 4'd1;
    assign to_lock = (fail_d == 4'(MAX_FAILS));

`ifdef LOCKOUT_ESCALATE_EN
    logic [2:0] lvl_q;

    assign lock_load = lockout_time(8'(LOCKOUT_SECS), lvl_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lvl_q <= '0;
        end else if (state_q == CHECK) begin
            if (match) begin
                lvl_q <= '0;
            end else if (to_lock && (lvl_q != 3'd7)) begin
                lvl_q <= lvl_q + 3'd1;
            end
        end
    end
`else
    assign lock_load = 8'(LOCKOUT_SECS);
`endif

    // One timer serves both GRANT and LOCKOUT; it is only loaded on CHECK
    // outcomes that actually enter one of those states.
    assign tmr_load  = (state_q == CHECK) && (match || to_lock);
    assign tmr_value = match ? 8'(UNLOCK_SECS) : lock_load;

    verify_pin_sec_timer #(
        .TICK_HZ (TICK_HZ)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load_i  (tmr_load),
        .value_i (tmr_value),
        .secs_o  (tmr_secs),
        .done_o  (tmr_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            prev_q   <= 1'b1;
            unlock_q <= 1'b0;
            denied_q <= 1'b0;
            locked_q <= 1'b0;
            fail_q   <= '0;
        end else begin
            // Edge register always tracks status, so edges seen outside IDLE
            // (including on a timer-expiry cycle) are consumed, not deferred.
            prev_q   <= bus.pin_in.status;
            denied_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (attempt) begin
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    if (match) begin
                        state_q  <= GRANT;
                        unlock_q <= 1'b1;
                        fail_q   <= '0;
                    end else begin
                        denied_q <= 1'b1;
                        fail_q   <= fail_d;
                        if (to_lock) begin
                            state_q  <= LOCKOUT;
                            locked_q <= 1'b1;
                        end else begin
                            state_q  <= IDLE;
                        end
                    end
                end
                GRANT: begin
                    if (tmr_done) begin
                        state_q  <= IDLE;
                        unlock_q <= 1'b0;
                    end
                end
                LOCKOUT: begin
                    if (tmr_done) begin
                        state_q  <= IDLE;
                        locked_q <= 1'b0;
                        fail_q   <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.unlock    = unlock_q;
    assign bus.denied    = denied_q;
    assign bus.locked    = locked_q;
    assign bus.fail_cnt  = fail_q;
    assign bus.lock_secs = locked_q ? tmr_secs : 8'd0;

endmodule
